// File: rtl/gameboy_lcd_pixel_tx.sv
// GameBoy LCD pixel transmitter: FIFO-buffered PPU shades out on LD/PX_VALID,
// with exactly H_PIXELS*V_LINES beats per frame (aborted frames are padded).
// Ports:
//   GameBoy_clk, GameBoy_reset_n (async, active-low)
//   lcd_on              LCDC enable level
//   pix_in/_valid/_ready  shade input handshake
//   palette             BGP-style map (GAMEBOY_LCD_PIXEL_TX_PALETTE_EN only)
//   LD, PX_VALID        pixel beat to frame buffer
//   pix_x, pix_y        position of the beat on LD
//   frame_done          pulse with last beat of a frame
//   pad_active          high while padding an aborted frame
// Option macro: GAMEBOY_LCD_PIXEL_TX_PALETTE_EN maps FIFO shades through palette.
module gameboy_lcd_pixel_tx #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         H_PIXELS   = 160,
  parameter int         V_LINES    = 144,
  parameter logic [1:0] PAD_SHADE  = 2'b00
) (
  input  logic       GameBoy_clk,
  input  logic       GameBoy_reset_n,
  input  logic       lcd_on,
  input  logic [1:0] pix_in,
  input  logic       pix_in_valid,
  output logic       pix_in_ready,
  input  logic [7:0] palette,
  output logic [1:0] LD,
  output logic       PX_VALID,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       frame_done,
  output logic       pad_active
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_PAD    = 2'd2;

  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic [1:0]  r_mem [FIFO_DEPTH];
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;

  // position the next emitted beat will carry
  logic [7:0]  r_nx;
  logic [7:0]  r_ny;

  logic [1:0]  r_ld;
  logic        r_px_valid;
  logic [7:0]  r_pix_x;
  logic [7:0]  r_pix_y;
  logic        r_frame_done;
  logic        r_pad_active;

  logic        w_off;
  logic        w_active;
  logic        w_pad;
  logic        w_empty;
  logic        w_full;
  logic        w_aligned;
  logic        w_last;
  logic        w_push;
  logic        w_pop;
  logic        w_beat;
  logic        w_fifo_clr;
  logic [1:0]  w_pop_shade;
  logic [1:0]  w_pop_ld;

  assign w_off    = (r_state == S_OFF);
  assign w_active = (r_state == S_ACTIVE);
  assign w_pad    = (r_state == S_PAD);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  assign w_aligned = (r_nx == 8'd0) && (r_ny == 8'd0);
  assign w_last    = (r_nx == X_LAST) && (r_ny == Y_LAST);

  assign pix_in_ready = w_active && !w_full;

  assign w_push = pix_in_valid && pix_in_ready;
  // lcd_on low in ACTIVE is the abort cycle: nothing is popped
  assign w_pop  = w_active && lcd_on && !w_empty;
  assign w_beat = w_pop || w_pad;

  // FIFO emptied entering ACTIVE and when leaving it
  assign w_fifo_clr = (w_off && lcd_on) || (w_active && !lcd_on);

  assign w_pop_shade = r_mem[r_rd_ptr[PW-1:0]];

`ifdef GAMEBOY_LCD_PIXEL_TX_PALETTE_EN
  assign w_pop_ld = palette[{w_pop_shade, 1'b0} +: 2];
`else
  logic w_unused_palette;
  assign w_unused_palette = ^palette;
  assign w_pop_ld = w_pop_shade;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_off: begin
        if (lcd_on) w_state_nxt = S_ACTIVE;
      end
      w_active: begin
        if (!lcd_on)
          w_state_nxt = w_aligned ? S_OFF : S_PAD;
      end
      w_pad: begin
        if (w_last) w_state_nxt = S_OFF;
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_fifo_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 2'b00;
    end else if (w_push && !w_fifo_clr) begin
      r_mem[r_wr_ptr[PW-1:0]] <= pix_in;
    end
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      r_nx <= 8'd0;
      r_ny <= 8'd0;
    end else if (w_off) begin
      r_nx <= 8'd0;
      r_ny <= 8'd0;
    end else if (w_beat) begin
      if (r_nx == X_LAST) begin
        r_nx <= 8'd0;
        r_ny <= (r_ny == Y_LAST) ? 8'd0 : r_ny + 8'd1;
      end else begin
        r_nx <= r_nx + 8'd1;
      end
    end
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      r_ld         <= 2'b00;
      r_px_valid   <= 1'b0;
      r_pix_x      <= 8'd0;
      r_pix_y      <= 8'd0;
      r_frame_done <= 1'b0;
    end else if (w_beat) begin
      // pad beats bypass any palette mapping
      r_ld         <= w_pad ? PAD_SHADE : w_pop_ld;
      r_px_valid   <= 1'b1;
      r_pix_x      <= r_nx;
      r_pix_y      <= r_ny;
      r_frame_done <= w_last;
    end else begin
      r_px_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_off) begin
        r_ld    <= 2'b00;
        r_pix_x <= 8'd0;
        r_pix_y <= 8'd0;
      end
    end
  end

  // covers the abort cycle and every pad beat, including the last
  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      r_pad_active <= 1'b0;
    end else begin
      r_pad_active <= w_pad || (w_state_nxt == S_PAD);
    end
  end

  assign LD         = r_ld;
  assign PX_VALID   = r_px_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign frame_done = r_frame_done;
  assign pad_active = r_pad_active;

endmodule
